hazard_stall_unit: RTL and testbench

- Pipeline control block that drives the freeze and flush inputs of the PC, IF2ID, ID2EX and EX2MEM pipeline registers.
- Detects load-use hazards between the ID and EX stages.
- Holds the pipeline for multi-cycle multiply/divide operations occupying EX.
- Squashes the fetched instruction on a taken branch resolved in ID.
- Keeps a saturating count of stall cycles for performance debug.

---
 rtl/hazard_stall_unit.sv | 151 +++++++++++++++
 tb/tb_hazard_stall_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : Pipeline hazard control. Drives the freeze/flush controls of
//               the PC, IF2ID, ID2EX and EX2MEM registers for three cases:
//               load-use hazards (ID vs EX), multi-cycle mul/div ops that
//               occupy EX, and taken branches resolved in ID. Also keeps a
//               saturating count of stall cycles (cycles with PC held).
// Ports       : clk, rest          - clock, async active-high reset
//               ID_Rs/ID_Rt        - ID source registers
//               ID_Uses_Rs/Rt      - ID instruction actually reads Rs/Rt
//               Branch_Taken       - branch in ID resolved taken
//               EX_OpCode          - opcode in ID2EX
//               EX_MemRead, EX_Rt  - EX instruction is a load, its dest reg
//               *_Freze / *_Flush  - pipeline register controls
//               Stall_Cycles       - saturating stall-cycle counter
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int         MD_LATENCY = 4,      // legal 2..15
    parameter logic [3:0] MUL_OPCODE = 4'hC,
    parameter logic [3:0] DIV_OPCODE = 4'hD
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [3:0]  ID_Rs,
    input  logic [3:0]  ID_Rt,
    input  logic        ID_Uses_Rs,
    input  logic        ID_Uses_Rt,
    input  logic        Branch_Taken,
    input  logic [3:0]  EX_OpCode,
    input  logic        EX_MemRead,
    input  logic [3:0]  EX_Rt,
    output logic        PC_Freze,
    output logic        IF2ID_Freze,
    output logic        ID2EX_Freze,
    output logic        IF2ID_Flush,
    output logic        ID2EX_Flush,
    output logic        EX2MEM_Flush,
    output logic [15:0] Stall_Cycles
);

    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_MD_WAIT = 1'b1
    } state_t;

    // The detect cycle in RUN is the first freeze cycle and the release cycle
    // in MD_WAIT is the last EX cycle, so MD_WAIT only needs to count the
    // MD_LATENCY-2 freeze cycles in between.
    localparam logic [3:0] c_MD_LOAD = 4'(MD_LATENCY - 2);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_md_cnt;
    logic [3:0]  w_md_cnt_nxt;
    logic [15:0] r_stall_cnt;

    logic        w_is_md;
    logic        w_rs_hit;
    logic        w_rt_hit;
    logic        w_load_use;

    assign w_is_md    = (EX_OpCode == MUL_OPCODE) || (EX_OpCode == DIV_OPCODE);
    assign w_rs_hit   = ID_Uses_Rs && (ID_Rs == EX_Rt);
    assign w_rt_hit   = ID_Uses_Rt && (ID_Rt == EX_Rt);
    // R0 is hardwired, so a load targeting it can never feed a consumer.
    assign w_load_use = EX_MemRead && (EX_Rt != 4'd0) && (w_rs_hit || w_rt_hit);

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        PC_Freze     = 1'b0;
        IF2ID_Freze  = 1'b0;
        ID2EX_Freze  = 1'b0;
        IF2ID_Flush  = 1'b0;
        ID2EX_Flush  = 1'b0;
        EX2MEM_Flush = 1'b0;

        // Outputs are forced idle for the whole time reset is held, even if
        // the inputs would otherwise request a stall.
        if (!rest) begin
            case (r_state)
                S_RUN: begin
                    if (w_is_md) begin
                        PC_Freze     = 1'b1;
                        IF2ID_Freze  = 1'b1;
                        ID2EX_Freze  = 1'b1;
                        EX2MEM_Flush = 1'b1;
                        w_state_nxt  = S_MD_WAIT;
                        w_md_cnt_nxt = c_MD_LOAD;
                    end else if (w_load_use) begin
                        // One bubble: the load moves to MEM and the hazard
                        // clears on its own next cycle.
                        PC_Freze     = 1'b1;
                        IF2ID_Freze  = 1'b1;
                        ID2EX_Flush  = 1'b1;
                    end else if (Branch_Taken) begin
                        IF2ID_Flush  = 1'b1;
                    end
                end

                S_MD_WAIT: begin
                    // ID/EX inputs are ignored here; a frozen taken branch in
                    // ID is still asserted and gets handled back in RUN.
                    if (r_md_cnt != 4'd0) begin
                        PC_Freze     = 1'b1;
                        IF2ID_Freze  = 1'b1;
                        ID2EX_Freze  = 1'b1;
                        EX2MEM_Flush = 1'b1;
                        w_md_cnt_nxt = r_md_cnt - 4'd1;
                    end else begin
                        // Release cycle: result advances; returning to RUN
                        // without re-evaluating is_md avoids re-detecting the
                        // op that is still visible in EX this cycle.
                        w_state_nxt  = S_RUN;
                    end
                end

                default: begin
                    w_state_nxt  = S_RUN;
                    w_md_cnt_nxt = 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State, mul/div counter and stall counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_state     <= S_RUN;
            r_md_cnt    <= 4'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
            if (PC_Freze && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign Stall_Cycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_unit
// Description : Self-checking bench for hazard_stall_unit. Table-driven RUN
//               vectors, hand-written mul/div, branch, saturation and async
//               reset sequences, plus random stimulus against a reference
//               model that tracks how many cycles the current mul/div op
//               still occupies EX.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    localparam int         MD_LAT = 4;
    localparam logic [3:0] OP_MUL = 4'hC;
    localparam logic [3:0] OP_DIV = 4'hD;

    // flag vector order: {PC_Freze, IF2ID_Freze, ID2EX_Freze,
    //                     IF2ID_Flush, ID2EX_Flush, EX2MEM_Flush}
    localparam logic [5:0] F_IDLE = 6'b000000;
    localparam logic [5:0] F_LU   = 6'b110010;
    localparam logic [5:0] F_MD   = 6'b111001;
    localparam logic [5:0] F_BR   = 6'b000100;

    logic        clk = 1'b0;
    logic        rest;
    logic [3:0]  ID_Rs, ID_Rt, EX_OpCode, EX_Rt;
    logic        ID_Uses_Rs, ID_Uses_Rt, Branch_Taken, EX_MemRead;
    logic        PC_Freze, IF2ID_Freze, ID2EX_Freze;
    logic        IF2ID_Flush, ID2EX_Flush, EX2MEM_Flush;
    logic [15:0] Stall_Cycles;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_busy  = 0;   // cycles the current mul/div still occupies EX
    int m_stall = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(
        .MD_LATENCY (MD_LAT),
        .MUL_OPCODE (OP_MUL),
        .DIV_OPCODE (OP_DIV)
    ) dut (
        .clk          (clk),
        .rest         (rest),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_Uses_Rs   (ID_Uses_Rs),
        .ID_Uses_Rt   (ID_Uses_Rt),
        .Branch_Taken (Branch_Taken),
        .EX_OpCode    (EX_OpCode),
        .EX_MemRead   (EX_MemRead),
        .EX_Rt        (EX_Rt),
        .PC_Freze     (PC_Freze),
        .IF2ID_Freze  (IF2ID_Freze),
        .ID2EX_Freze  (ID2EX_Freze),
        .IF2ID_Flush  (IF2ID_Flush),
        .ID2EX_Flush  (ID2EX_Flush),
        .EX2MEM_Flush (EX2MEM_Flush),
        .Stall_Cycles (Stall_Cycles)
    );

    typedef struct {
        string      name;
        logic [3:0] rs, rt, op, ex_rt;
        logic       urs, urt, br, mr;
        logic [5:0] exp;
    } vec_t;

    function automatic logic in_is_md();
        return (EX_OpCode == OP_MUL) || (EX_OpCode == OP_DIV);
    endfunction

    function automatic logic [5:0] model_flags();
        logic lu;
        lu = EX_MemRead && (EX_Rt != 0) &&
             ((ID_Uses_Rs && ID_Rs == EX_Rt) || (ID_Uses_Rt && ID_Rt == EX_Rt));
        if (rest)        return F_IDLE;
        if (m_busy > 1)  return F_MD;     // op still needs more EX cycles
        if (m_busy == 1) return F_IDLE;   // last EX cycle: result leaves
        if (in_is_md())  return F_MD;
        if (lu)          return F_LU;
        if (Branch_Taken) return F_BR;
        return F_IDLE;
    endfunction

    task automatic set_in(input logic [3:0] rs, input logic urs,
                          input logic [3:0] rt, input logic urt,
                          input logic br, input logic [3:0] op,
                          input logic mr, input logic [3:0] ert);
        ID_Rs = rs; ID_Uses_Rs = urs; ID_Rt = rt; ID_Uses_Rt = urt;
        Branch_Taken = br; EX_OpCode = op; EX_MemRead = mr; EX_Rt = ert;
    endtask

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {PC_Freze, IF2ID_Freze, ID2EX_Freze, IF2ID_Flush, ID2EX_Flush, EX2MEM_Flush};
        n_vec++;
        if (act !== exp || Stall_Cycles !== 16'(m_stall)) begin
            n_err++;
            $display("FAIL %s: flags=%b stall=%h, expected flags=%b stall=%h",
                     name, act, Stall_Cycles, exp, 16'(m_stall));
        end
    endtask

    // Advance one clock, updating the model with the pre-edge inputs.
    task automatic tick();
        logic [5:0] f;
        logic       md;
        f  = model_flags();
        md = in_is_md();
        @(posedge clk);
        if (m_busy > 0)  m_busy--;
        else if (md)     m_busy = MD_LAT - 1;
        if (f[5] && m_stall < 65535) m_stall++;
        #1;
    endtask

    task automatic step(input string name, input logic [5:0] exp);
        #2;
        check(name, exp);
        tick();
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"idle",        4'd0,4'd0,4'h0,4'd0, 1'b0,1'b0,1'b0,1'b0, F_IDLE});
        vecs.push_back('{"lu_rs",       4'd3,4'd0,4'h0,4'd3, 1'b1,1'b0,1'b0,1'b1, F_LU});
        vecs.push_back('{"lu_r0",       4'd0,4'd0,4'h0,4'd0, 1'b1,1'b1,1'b0,1'b1, F_IDLE});
        vecs.push_back('{"lu_nouse",    4'd3,4'd0,4'h0,4'd3, 1'b0,1'b0,1'b0,1'b1, F_IDLE});
        vecs.push_back('{"lu_rt",       4'd1,4'd5,4'h0,4'd5, 1'b1,1'b1,1'b0,1'b1, F_LU});
        vecs.push_back('{"no_load",     4'd5,4'd5,4'h0,4'd5, 1'b1,1'b1,1'b0,1'b0, F_IDLE});
        vecs.push_back('{"rt_nouse",    4'd2,4'd7,4'h0,4'd7, 1'b1,1'b0,1'b0,1'b1, F_IDLE});
        vecs.push_back('{"branch",      4'd0,4'd0,4'h1,4'd0, 1'b0,1'b0,1'b1,1'b0, F_BR});
        vecs.push_back('{"lu_and_br",   4'd9,4'd0,4'h2,4'd9, 1'b1,1'b0,1'b1,1'b1, F_LU});
        vecs.push_back('{"br_after_lu", 4'd9,4'd0,4'h2,4'd1, 1'b1,1'b0,1'b1,1'b0, F_BR});
        vecs.push_back('{"op_near_md",  4'd0,4'd0,4'hB,4'd0, 1'b0,1'b0,1'b0,1'b0, F_IDLE});

        // reset
        rest = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        check("in_reset", F_IDLE);
        @(posedge clk); #1;
        rest = 1'b0;
        step("after_reset", F_IDLE);

        // table vectors, all starting and staying in RUN
        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].rs, vecs[i].urs, vecs[i].rt, vecs[i].urt,
                   vecs[i].br, vecs[i].op, vecs[i].mr, vecs[i].ex_rt);
            step(vecs[i].name, vecs[i].exp);
        end

        // MUL, then a second MUL back to back
        set_in(0, 0, 0, 0, 0, OP_MUL, 0, 0);
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < MD_LAT - 1; c++) step("mul_hold", F_MD);
            step("mul_release", F_IDLE);
        end
        set_in(0, 0, 0, 0, 0, 4'h0, 0, 0);
        step("mul_done", F_IDLE);

        // DIV with a taken branch waiting in ID
        set_in(0, 0, 0, 0, 1, OP_DIV, 0, 0);
        for (int c = 0; c < MD_LAT - 1; c++) step("div_br_hold", F_MD);
        step("div_br_release", F_IDLE);
        set_in(0, 0, 0, 0, 1, 4'h0, 0, 0);
        step("br_after_div", F_BR);

        // randomized against the model
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] op;
            if ($urandom_range(0, 5) == 0) op = $urandom_range(0, 1) ? OP_MUL : OP_DIV;
            else                           op = 4'($urandom_range(0, 11));
            set_in(4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), op, 1'($urandom), 4'($urandom_range(0, 3)));
            #2;
            check("random", model_flags());
            tick();
        end

        // saturation: continuous load-use stall
        set_in(0, 0, 0, 0, 0, 4'h0, 0, 0);
        step("pre_sat_idle", F_IDLE);
        set_in(3, 1, 0, 0, 0, 4'h0, 1, 3);
        for (int n = 0; n < 65540; n++) tick();
        step("sat_hold", F_LU);
        n_vec++;
        if (Stall_Cycles !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_value: stall=%h, expected %h", Stall_Cycles, 16'hFFFF);
        end

        // async reset in the middle of MD_WAIT
        set_in(0, 0, 0, 0, 0, OP_MUL, 0, 0);
        step("md_detect", F_MD);
        #2;
        check("md_wait", F_MD);
        #1;
        rest = 1'b1;
        m_busy  = 0;
        m_stall = 0;
        #1;
        check("async_reset", F_IDLE);
        @(posedge clk); #1;
        rest = 1'b0;
        set_in(0, 0, 0, 0, 0, 4'h0, 0, 0);
        step("post_reset_idle", F_IDLE);
        set_in(0, 0, 0, 0, 0, OP_MUL, 0, 0);
        step("post_reset_mul", F_MD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
